io_trap_controller: RTL

// Sequences the mapper's I/O trap: detects CPU I/O cycles to a trapped port window, latches

---
 rtl/io_trap_controller.sv | 85 ++++++++
 1 files changed

// File: rtl/io_trap_controller.sv
// io_trap_controller: detects I/O cycles to the trapped port window, latches the access,
// fires an NMI and holds trap context until the handler's untrapping RETN.
module io_trap_controller #(
    parameter logic [7:0] TRAP_LO    = 8'hA0,
    parameter logic [7:0] TRAP_HI    = 8'hA1,
    parameter int         NMI_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iorq_n,
    input  logic       m1_n,
    input  logic       wr_n,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    input  logic       trap_en,
    input  logic       io_direction,
    input  logic       last_isr_untrap,
    output logic       ignore_next_isr,
    output logic       nmi_n,
    output logic       trapped,
    output logic       trap_valid,
    output logic [7:0] trap_addr,
    output logic [7:0] trap_data,
    output logic       trap_dir
);
    typedef enum logic [1:0] {IDLE, ARM, NMI, TRAPPED} state_t;

    state_t     state, state_nx;
    logic [2:0] iorq_sr, m1_sr;
    logic [1:0] wr_sr;
    logic [3:0] cnt;
    logic       untrap_chk;
    logic       io_cycle, iorq_rise, m1_rise, in_win;

    // [1] is the synchronised level, [2] its one-clock delay for edge detection
    assign io_cycle  = !iorq_sr[1] && m1_sr[1];
    assign iorq_rise = iorq_sr[1] && !iorq_sr[2];
    assign m1_rise   = m1_sr[1] && !m1_sr[2];
    assign in_win    = (addr >= TRAP_LO) && (addr <= TRAP_HI);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (io_cycle && trap_en && in_win) ? ARM : IDLE;
            ARM:     state_nx = iorq_rise ? NMI : ARM;
            NMI:     state_nx = (cnt == 4'd0) ? TRAPPED : NMI;
            TRAPPED: state_nx = (untrap_chk && last_isr_untrap) ? IDLE : TRAPPED;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            iorq_sr         <= 3'b111;
            m1_sr           <= 3'b111;
            wr_sr           <= 2'b11;
            cnt             <= 4'd0;
            untrap_chk      <= 1'b0;
            ignore_next_isr <= 1'b1;
            nmi_n           <= 1'b1;
            trapped         <= 1'b0;
            trap_valid      <= 1'b0;
            trap_addr       <= 8'h00;
            trap_data       <= 8'h00;
            trap_dir        <= 1'b0;
        end else begin
            state           <= state_nx;
            iorq_sr         <= {iorq_sr[1:0], iorq_n};
            m1_sr           <= {m1_sr[1:0], m1_n};
            wr_sr           <= {wr_sr[0], wr_n};
            cnt             <= (state == NMI) ? cnt - 4'd1 : 4'(NMI_CYCLES - 1);
            untrap_chk      <= (state == TRAPPED) && m1_rise;
            ignore_next_isr <= state_nx != TRAPPED;
            nmi_n           <= state_nx != NMI;
            trapped         <= state_nx == TRAPPED;
            trap_valid      <= (state_nx == NMI) || (state_nx == TRAPPED);
            if (state == ARM && !iorq_sr[1]) begin
                trap_addr <= addr;
                trap_dir  <= io_direction;
                trap_data <= !wr_sr[1] ? data_in : 8'h00;
            end
        end
    end
endmodule
